// File: rtl/frame_pkg.sv
// Shared constants, types and state encoding for the SRAM frame reader.
package frame_pkg;

    localparam int unsigned SRAM_PARALLEL = 6;
    localparam int unsigned PIXEL_COLUMN  = 80;
    localparam int unsigned PIXEL_ROW     = 60;
    localparam int unsigned NUM_PIXELS    = PIXEL_COLUMN * PIXEL_ROW;
    localparam int unsigned ADDR_W        = 13;
    localparam int unsigned DATA_W        = 16;

    localparam int unsigned X_W        = 7;
    localparam int unsigned Y_W        = 6;
    localparam int unsigned NUM_GROUPS = NUM_PIXELS / SRAM_PARALLEL;
    localparam int unsigned GRP_W      = $clog2(NUM_GROUPS + 1);
    localparam int unsigned IDX_W      = $clog2(SRAM_PARALLEL);

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } reader_state_t;

endpackage

// File: rtl/frame_xy_counter.sv
// Raster x/y position of the pixel currently on the output stream.
//   i_clk, i_rst : clock, async active-high reset
//   i_clear      : return to (0,0) (frame start)
//   i_advance    : pixel handshake, step to next raster position
//   i_valid      : stream valid, qualifies sof/eof
//   o_x, o_y     : current column / row
//   o_sof, o_eof : first / last pixel of frame on the stream
//   o_last       : position is (79,59), independent of valid
module frame_xy_counter
    import frame_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_clear,
    input  logic           i_advance,
    input  logic           i_valid,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_sof,
    output logic           o_eof,
    output logic           o_last
);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic           w_x_end;
    logic           w_y_end;

    assign w_x_end = (r_x == X_W'(PIXEL_COLUMN - 1));
    assign w_y_end = (r_y == Y_W'(PIXEL_ROW - 1));

    // Raster stepping; wraps to (0,0) after the last pixel so looping needs no clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end & w_y_end;
    assign o_sof  = i_valid & (r_x == '0) & (r_y == '0);
    assign o_eof  = i_valid & o_last;

endmodule

// File: rtl/sram_frame_reader.sv
// Raster scan of an 80x60 pixel SRAM through 6 parallel read ports into a
// ping-pong group buffer, streamed out one pixel per cycle on valid/ready.
// Optional macro SRAM_FRAME_READER_LOOP_EN: repeat frames until i_stop.
//   i_clk, i_rst        : clock, async active-high reset
//   i_start / i_stop    : begin scan (IDLE only) / end looping after frame
//   o_read_address      : 6 consecutive SRAM addresses (group_base + k)
//   i_read_data         : combinational SRAM data for those addresses
//   o_pixel_*           : pixel stream with x/y and frame markers
//   i_pixel_ready       : stream back-pressure
//   o_busy / o_done     : scan active / one-cycle end-of-frame pulse
module sram_frame_reader
    import frame_pkg::*;
(
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic                                  i_stop,
    output logic [SRAM_PARALLEL-1:0][ADDR_W-1:0]  o_read_address,
    input  logic [SRAM_PARALLEL-1:0][DATA_W-1:0]  i_read_data,
    output logic [DATA_W-1:0]                     o_pixel_data,
    output logic [X_W-1:0]                        o_pixel_x,
    output logic [Y_W-1:0]                        o_pixel_y,
    output logic                                  o_pixel_sof,
    output logic                                  o_pixel_eof,
    output logic                                  o_pixel_valid,
    input  logic                                  i_pixel_ready,
    output logic                                  o_busy,
    output logic                                  o_done
);

    reader_state_t    r_state,       w_state_nxt;
    addr_t            r_group_base,  w_group_base_nxt;
    logic [GRP_W-1:0] r_groups,      w_groups_nxt;
    logic [1:0]       r_full,        w_full_nxt;
    logic             r_fill_bank,   w_fill_bank_nxt;
    logic             r_rd_bank,     w_rd_bank_nxt;
    logic [IDX_W-1:0] r_rd_idx,      w_rd_idx_nxt;
    logic             r_done,        w_done_nxt;
    logic             r_stop_seen,   w_stop_seen_nxt;

    logic [1:0][SRAM_PARALLEL-1:0][DATA_W-1:0] r_bank;

    logic w_valid;
    logic w_hs;
    logic w_fetch;
    logic w_last;
    logic w_xy_clear;
    logic w_wrap;

`ifdef SRAM_FRAME_READER_LOOP_EN
    // Keep scanning unless a stop has been requested during this run
    assign w_wrap = ~(r_stop_seen | i_stop);
`else
    assign w_wrap = 1'b0;
`endif

    assign w_valid = r_full[r_rd_bank];
    assign w_hs    = (r_state == RUN) & w_valid & i_pixel_ready;
    assign w_fetch = (r_state == RUN) & ~r_full[r_fill_bank]
                   & (r_groups < GRP_W'(NUM_GROUPS));

    for (genvar k = 0; k < SRAM_PARALLEL; k++) begin : g_addr
        assign o_read_address[k] = r_group_base + ADDR_W'(k);
    end

    frame_xy_counter u_xy (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (w_xy_clear),
        .i_advance (w_hs),
        .i_valid   (w_valid),
        .o_x       (o_pixel_x),
        .o_y       (o_pixel_y),
        .o_sof     (o_pixel_sof),
        .o_eof     (o_pixel_eof),
        .o_last    (w_last)
    );

    // Group capture into the empty bank; data is only consumed while its flag is set
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bank <= '0;
        end else if (w_fetch) begin
            r_bank[r_fill_bank] <= i_read_data;
        end
    end

    // State and control registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_group_base <= '0;
            r_groups     <= '0;
            r_full       <= '0;
            r_fill_bank  <= 1'b0;
            r_rd_bank    <= 1'b0;
            r_rd_idx     <= '0;
            r_done       <= 1'b0;
            r_stop_seen  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_group_base <= w_group_base_nxt;
            r_groups     <= w_groups_nxt;
            r_full       <= w_full_nxt;
            r_fill_bank  <= w_fill_bank_nxt;
            r_rd_bank    <= w_rd_bank_nxt;
            r_rd_idx     <= w_rd_idx_nxt;
            r_done       <= w_done_nxt;
            r_stop_seen  <= w_stop_seen_nxt;
        end
    end

    // Next-state: fetch and drain touch different banks, so both may act in one cycle
    always_comb begin
        w_state_nxt      = r_state;
        w_group_base_nxt = r_group_base;
        w_groups_nxt     = r_groups;
        w_full_nxt       = r_full;
        w_fill_bank_nxt  = r_fill_bank;
        w_rd_bank_nxt    = r_rd_bank;
        w_rd_idx_nxt     = r_rd_idx;
        w_done_nxt       = 1'b0;
        w_stop_seen_nxt  = r_stop_seen;
        w_xy_clear       = 1'b0;

        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt      = RUN;
                    w_group_base_nxt = '0;
                    w_groups_nxt     = '0;
                    w_stop_seen_nxt  = 1'b0;
                    w_xy_clear       = 1'b1;
                end
            end
            RUN: begin
                if (i_stop) begin
                    w_stop_seen_nxt = 1'b1;
                end
                if (w_fetch) begin
                    w_full_nxt[r_fill_bank] = 1'b1;
                    w_fill_bank_nxt         = ~r_fill_bank;
                    // Last group: hold the base at its final value, or wrap to prefetch the next frame
                    if (r_groups == GRP_W'(NUM_GROUPS - 1)) begin
                        if (w_wrap) begin
                            w_group_base_nxt = '0;
                            w_groups_nxt     = '0;
                        end else begin
                            w_groups_nxt = r_groups + GRP_W'(1);
                        end
                    end else begin
                        w_group_base_nxt = r_group_base + ADDR_W'(SRAM_PARALLEL);
                        w_groups_nxt     = r_groups + GRP_W'(1);
                    end
                end
                if (w_hs) begin
                    if (r_rd_idx == IDX_W'(SRAM_PARALLEL - 1)) begin
                        w_full_nxt[r_rd_bank] = 1'b0;
                        w_rd_bank_nxt         = ~r_rd_bank;
                        w_rd_idx_nxt          = '0;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
                    end
                    if (w_last) begin
                        w_done_nxt = 1'b1;
                        // Stopping discards any group already prefetched for a next frame
                        if (!w_wrap) begin
                            w_state_nxt      = IDLE;
                            w_group_base_nxt = '0;
                            w_groups_nxt     = '0;
                            w_full_nxt       = '0;
                            w_fill_bank_nxt  = 1'b0;
                            w_rd_bank_nxt    = 1'b0;
                            w_rd_idx_nxt     = '0;
                            w_stop_seen_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign o_pixel_valid = w_valid;
    assign o_pixel_data  = r_bank[r_rd_bank][r_rd_idx];
    assign o_busy        = (r_state == RUN);
    assign o_done        = r_done;

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with an SRAM model holding mem[a] = a.
`timescale 1ns/1ps
module tb_sram_frame_reader;
    import frame_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic stop;
    logic ready;
    logic [SRAM_PARALLEL-1:0][ADDR_W-1:0] rd_addr;
    logic [SRAM_PARALLEL-1:0][DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] pix_data;
    logic [X_W-1:0]    px;
    logic [Y_W-1:0]    py;
    logic sof, eof, valid, busy, done;

    sram_frame_reader dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_stop         (stop),
        .o_read_address (rd_addr),
        .i_read_data    (rd_data),
        .o_pixel_data   (pix_data),
        .o_pixel_x      (px),
        .o_pixel_y      (py),
        .o_pixel_sof    (sof),
        .o_pixel_eof    (eof),
        .o_pixel_valid  (valid),
        .i_pixel_ready  (ready),
        .o_busy         (busy),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    // Combinational SRAM: each word holds its own address
    always_comb begin
        for (int k = 0; k < SRAM_PARALLEL; k++) rd_data[k] = DATA_W'(rd_addr[k]);
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int max_addr = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        for (int k = 0; k < SRAM_PARALLEL; k++)
            if (int'(rd_addr[k]) > max_addr) max_addr = int'(rd_addr[k]);
    end

    int tot;
    int seq_err, xy_err, sof_err, eof_err, hold_err;
    int first_valid_cyc;
    int start_cyc;
    logic [31:0] x80, y80;

    task automatic clear_stats();
        tot = 0; seq_err = 0; xy_err = 0; sof_err = 0; eof_err = 0; hold_err = 0;
        done_cnt = 0; first_valid_cyc = -1; x80 = '1; y80 = '1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Consume n pixels against the raster model; start/stop pulsed at given pixel counts
    task automatic stream(input string tag, input int n, input bit rnd,
                          input int start_at, input int stop_at);
        int budget;
        int got;
        int f;
        bit held;
        logic [DATA_W-1:0] h_data;
        logic [X_W-1:0] hx;
        logic [Y_W-1:0] hy;
        budget = 0; got = 0; held = 1'b0;
        h_data = '0; hx = '0; hy = '0;
        while (got < n && budget < 40000) begin
            @(negedge clk);
            budget++;
            start = (tot == start_at);
            stop  = (tot == stop_at);
            if (held && (valid !== 1'b1 || pix_data !== h_data || px !== hx || py !== hy))
                hold_err++;
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            if (valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (ready) begin
                    f = tot % NUM_PIXELS;
                    if (pix_data !== DATA_W'(f)) seq_err++;
                    if (int'(px) != f % PIXEL_COLUMN || int'(py) != f / PIXEL_COLUMN) xy_err++;
                    if (sof !== (f == 0)) sof_err++;
                    if (eof !== (f == NUM_PIXELS - 1)) eof_err++;
                    if (f == PIXEL_COLUMN) begin
                        x80 = 32'(px);
                        y80 = 32'(py);
                    end
                    tot++;
                    got++;
                end else begin
                    held = 1'b1;
                    h_data = pix_data; hx = px; hy = py;
                end
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        check({tag, "_pixel_count"}, got, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ready = 1'b0;
        start_cyc = 0;
        clear_stats();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_data", pix_data, 0);
        check("rst_x", px, 0);
        check("rst_y", py, 0);
        check("rst_sof", sof, 0);
        check("rst_eof", eof, 0);
        check("rst_addr0", rd_addr[0], 0);
        check("rst_addr5", rd_addr[5], 5);
        rst = 1'b0;

        // Frame 1: ready held high, latency and throughput
        ready = 1'b1;
        pulse_start();
        check("f1_valid_before_fetch", valid, 0);
        check("f1_busy", busy, 1);
        check("f1_addr0_start", rd_addr[0], 0);
        stream("f1", NUM_PIXELS, 1'b0, -1, 100);
        check("f1_first_valid_latency", first_valid_cyc - start_cyc, 2);
        @(negedge clk); #1;
        check("f1_done_cnt", done_cnt, 1);
        check("f1_done_from_first_valid", done_cyc - first_valid_cyc, NUM_PIXELS);
        check("f1_busy_at_done", busy, 0);
        check("f1_seq_err", seq_err, 0);
        check("f1_xy_err", xy_err, 0);
        check("f1_sof_err", sof_err, 0);
        check("f1_eof_err", eof_err, 0);
        check("f1_pix80_x", x80, 0);
        check("f1_pix80_y", y80, 1);
        check("max_read_address", max_addr, NUM_PIXELS - 1);
        @(negedge clk);
        check("f1_done_one_cycle", done, 0);
        check("f1_valid_idle", valid, 0);
        check("f1_addr0_idle", rd_addr[0], 0);

        // Frame 2: random back-pressure, stray i_start at pixel 1000
        clear_stats();
        pulse_start();
        stream("f2", NUM_PIXELS, 1'b1, 1000, 100);
        @(negedge clk); #1;
        check("f2_done_cnt", done_cnt, 1);
        check("f2_seq_err", seq_err, 0);
        check("f2_xy_err", xy_err, 0);
        check("f2_sof_err", sof_err, 0);
        check("f2_eof_err", eof_err, 0);
        check("f2_hold_err", hold_err, 0);
        repeat (4) @(negedge clk);
        check("f2_single_done", done_cnt, 1);
        check("f2_idle_valid", valid, 0);
        check("f2_idle_busy", busy, 0);

        // Reset at pixel 2500, then restart from pixel 0
        clear_stats();
        ready = 1'b1;
        pulse_start();
        stream("f3", 2500, 1'b0, -1, -1);
        rst = 1'b1;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_data", pix_data, 0);
        check("midrst_x", px, 0);
        check("midrst_y", py, 0);
        check("midrst_addr0", rd_addr[0], 0);
        @(negedge clk);
        rst = 1'b0;
        clear_stats();
        pulse_start();
        stream("f3r", 12, 1'b0, -1, -1);
        check("restart_seq_err", seq_err, 0);
        check("restart_xy_err", xy_err, 0);
        check("restart_no_done", done_cnt, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

`ifdef SRAM_FRAME_READER_LOOP_EN
        // Two back-to-back frames, stop requested during the second
        clear_stats();
        ready = 1'b1;
        pulse_start();
        stream("loop", 2 * NUM_PIXELS, 1'b0, -1, NUM_PIXELS + 100);
        @(negedge clk); #1;
        check("loop_done_cnt", done_cnt, 2);
        check("loop_no_gap", done_cyc - first_valid_cyc, 2 * NUM_PIXELS);
        check("loop_seq_err", seq_err, 0);
        check("loop_xy_err", xy_err, 0);
        check("loop_sof_err", sof_err, 0);
        check("loop_eof_err", eof_err, 0);
        check("loop_busy_after", busy, 0);
        repeat (6) @(negedge clk);
        check("loop_idle_valid", valid, 0);
        check("loop_done_final", done_cnt, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_frame_reader.md
Name: sram_frame_reader

Overview:
- Downstream consumer of the parallel multiport pixel SRAM (80x60 frame, 16-bit pixels, 6 combinational read ports).
- Scans one full frame in raster order, fetching 6 consecutive pixels per fetch cycle into a ping-pong group buffer.
- Emits one pixel per cycle on a valid/ready stream with x/y coordinates and frame markers, feeding the display/serial output stage.

Parameters:
- SRAM_PARALLEL, 6, read ports used per fetch (group size)
- PIXEL_COLUMN, 80, frame width
- PIXEL_ROW, 60, frame height
- ADDR_W, 13, SRAM address width
- DATA_W, 16, pixel width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start frame scan; sampled only in IDLE
- i_stop  in  1  end looping after current frame; used only with loop feature
- o_read_address  out  ADDR_W x SRAM_PARALLEL  SRAM read addresses
- i_read_data  in  DATA_W x SRAM_PARALLEL  SRAM read data, same-cycle combinational
- o_pixel_data  out  DATA_W  streamed pixel
- o_pixel_x  out  7  column of o_pixel_data, 0..79
- o_pixel_y  out  6  row of o_pixel_data, 0..59
- o_pixel_sof  out  1  high with pixel (0,0)
- o_pixel_eof  out  1  high with pixel (79,59)
- o_pixel_valid  out  1  stream valid
- i_pixel_ready  in  1  stream ready
- o_busy  out  1  scan in progress
- o_done  out  1  one-cycle pulse after last pixel handshake

Behaviour:
- Reset (async): state IDLE; group_base=0; both bank-full flags 0; read bank 0, rd_idx 0; x=y=0; all outputs 0.
- o_read_address[k] = group_base + k, driven combinationally from the group_base register at all times.
- States: IDLE, RUN.
  - IDLE -> RUN on i_start; on that edge group_base=0, x=y=0, and o_busy=1 from the next cycle.
  - i_start in RUN is ignored.
- Fetch: in RUN, if the fill bank is empty and groups_fetched < 800, capture all 6 i_read_data into the fill bank at the clock edge. Then set its full flag, toggle the fill bank, and advance group_base by 6.
  - At most one fetch per cycle.
- Stream: o_pixel_valid = full flag of the read bank; o_pixel_data = read bank[rd_idx].
  - Valid never depends on i_pixel_ready.
  - Data, x, y, sof and eof stay stable while valid and not ready.
- Handshake (valid & ready): rd_idx++.
  - At rd_idx=5: clear that bank's full flag, toggle the read bank, rd_idx=0.
  - x++; at 79, x=0 and y++.
- A bank cleared on cycle N may be refetched on cycle N+1 (no same-cycle clear and fill).
- Latency: i_start seen at edge E0 -> fetch captured at E1 -> o_pixel_valid=1 with pixel 0 after E1.
- Sustained throughput is 1 pixel/cycle with ready held high; no bubble after the first pixel.
- End of frame: handshake of (79,59) -> o_done=1 for one cycle, state IDLE, o_busy=0, flags cleared, group_base=0.
- group_base maximum is 4794 (addresses up to 4799); it is never driven beyond that.
- Reset mid-scan: immediate return to reset state; partial frame discarded.

Optional Feature:
- Macro: SRAM_FRAME_READER_LOOP_EN.
- Defined:
  - After the eof handshake, o_done still pulses.
  - If i_stop has not been seen since start, wrap (group_base=0, x=y=0, fetch counter cleared) and remain in RUN. Back-to-back frames run with no gap.
  - i_stop is latched while in RUN; the frame in progress completes, then the block enters IDLE.
- Undefined: i_stop ignored; single-frame behaviour as above.

Decomposition:
- Shared package frame_pkg holds:
  - constants PIXEL_COLUMN, PIXEL_ROW, NUM_PIXELS=4800, SRAM_PARALLEL, ADDR_W, DATA_W
  - typedefs pixel_t (DATA_W), addr_t (ADDR_W)
  - state enum reader_state_t {IDLE, RUN}
- One sub-module: frame_xy_counter. It advances x/y on handshake and generates sof/eof and a last-pixel flag.

Test Plan:
- SRAM preloaded mem[a]=a; pulse i_start, ready=1 -> first valid 2 edges after start; 4800 pixels with data=0..4799 consecutive; exactly 4800 cycles from first valid to o_done.
- Ready toggled pseudo-randomly -> data/x/y held stable while stalled; sequence unbroken; no pixel lost or duplicated.
- Check x/y/sof/eof -> pixel 80 has x=0, y=1; sof only on pixel 0; eof only on pixel 4799 (x=79, y=59).
- i_start pulsed mid-frame at pixel 1000 -> ignored; single o_done.
- i_rst asserted at pixel 2500 -> outputs 0 immediately; new i_start restarts at data 0.
- LOOP_EN defined, i_stop pulsed during frame 2 -> frames 1 and 2 complete back-to-back without gap; two o_done pulses; then IDLE.
